csr_file: RTL and testbench
===========================

# csr_file

Parametrised machine-mode CSR file for the RV32 core, replacing the flat 4096-entry CSR array with a sparse set of architected registers. It sits beside the integer register file in the execute/writeback stage and provides NUM_PORTS independent access ports, each performing CSRRW/CSRRS/CSRRC-style read-modify-write. Every port gets illegal-access detection, WARL field masking and free-running 64-bit cycle/instret counters.

## Interface
- NUM_PORTS, 3, number of access ports; port 0 has highest write priority
- HART_ID, 0, value returned by mhartid
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- csr_addr  in  NUM_PORTS*12  per-port CSR address; port i in bits [12*i +: 12]
- csr_op  in  NUM_PORTS*2  per-port op: 00 none, 01 write, 10 set-bits, 11 clear-bits
- csr_wd  in  NUM_PORTS*32  per-port operand
- csr_rd  out  NUM_PORTS*32  per-port read data, pre-update value
- csr_illegal  out  NUM_PORTS  per-port illegal-access flag
- retire  in  1  one instruction retired this cycle
- irq_ext, irq_timer, irq_soft  in  1 each  pending interrupt lines, level

## Operation
- Implemented registers:
  - mstatus 0x300: MIE[3] and MPIE[7] are RW; MPP[12:11] reads 11; all other bits read 0.
  - misa 0x301: RO, 0x4000_0100.
  - mie 0x304: RW bits 11, 7, 3 only.
  - mtvec 0x305: bits [1:0] read 00 and writes to them are ignored.
  - mscratch 0x340: full RW.
  - mepc 0x341: bits [1:0] forced 0.
  - mcause 0x342 and mtval 0x343: full RW.
  - mip 0x344: reads {irq_ext<<11, irq_timer<<7, irq_soft<<3}; writes are accepted and ignored.
  - mhartid 0xF14: RO, HART_ID.
  - Counters, see Configuration: mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82, and RO shadows cycle/cycleh/instret/instreth at 0xC00/0xC80/0xC02/0xC82.
- Per-port new value, with old = current read value:
  - op 01: new = wd.
  - op 10: new = old | wd.
  - op 11: new = old & ~wd.
  - The WARL mask is then applied.
- Illegal conditions (op != 00 is required for any flag):
  - the address is unimplemented, or
  - the address has bits [11:10] = 11 (read-only space) and the op is 01, or the op is 10/11 with wd != 0.
  - An illegal access suppresses the port's write.
  - csr_rd still returns 0 for unimplemented addresses.
- Set/clear with wd = 0 is a pure read: no write and no illegal flag, even for RO CSRs.
- Same-cycle writes to the same CSR: the lowest-index legal port wins; the other ports' writes are dropped. Distinct CSRs are all written.
- Counters:
  - mcycle increments by 1 every cycle.
  - minstret increments by 1 when retire = 1.
  - Each counter is 64-bit; carry propagates from the low word into the high word.
  - A software write to either half in a cycle replaces that half, and the counter does not increment that cycle. The unwritten half holds its old value.

## Timing
- Reads are combinational from addr and op. csr_rd and csr_illegal are valid in the same cycle.
- Writes and counter increments take effect at the next rising clk. A read in cycle N+1 sees a write made in cycle N; there is no bypass.
- rst_n low asynchronously clears all storage:
  - mstatus.MIE = MPIE = 0
  - mie, mtvec, mscratch, mepc, mcause, mtval = 0
  - counters = 0
- Reset mid-write: the write is lost and no partial state remains.
- csr_rd and csr_illegal have no reset value of their own. With csr_op = 00 during reset, csr_illegal = 0 and csr_rd shows the reset register contents.
- Counter wrap: 0xFFFF_FFFF_FFFF_FFFF increments to 0 with no flag.

## Configuration
- CSR_COUNTERS_EN defined:
  - mcycle/minstret (and their h halves) and the user shadows are implemented as described above.
  - The retire input is used.
- CSR_COUNTERS_EN undefined:
  - No counter storage is built.
  - All eight counter addresses are unimplemented: they read 0, and any op != 00 raises csr_illegal.
  - retire is ignored.

## Test plan
- Reset, then port 0 reads 0x301 with op 10 and wd 0 -> csr_rd0 = 0x4000_0100, illegal0 = 0. Read 0xF14 -> HART_ID.
- Port 0 writes 0x305 with 0x8000_0103; next cycle port 1 sets 0x305 with 0x10 -> reads 0x8000_0100, then 0x8000_0110. Clear with 0x8000_0000 -> 0x0000_0110.
- Same cycle, port 0 writes 0x340 = 0xAAAA_AAAA and port 2 writes 0x340 = 0x5555_5555 -> next cycle 0x340 reads 0xAAAA_AAAA.
- Write 0xC00, or access 0x7C0 with any op -> illegal = 1 and no state change. Set 0xC00 with wd 0 -> illegal = 0.
- Write mcycle = 0xFFFF_FFFE and mcycleh = 0 in the same cycle, then run 3 cycles -> mcycleh = 1, mcycle = 0x0000_0001. Drive retire for 5 cycles -> minstret = 5. With CSR_COUNTERS_EN undefined -> 0xB00 reads 0 and a write sets illegal = 1.
- Assert rst_n low mid-cycle while port 0 writes mscratch -> mscratch reads 0 immediately and after reset release.

Source files
------------

// File: rtl/csr_file_if.sv
// csr_file_if: per-port CSR access bundle shared by the core and the CSR file.
//   csr_addr    : NUM_PORTS x 12-bit CSR address, port i in [12*i +: 12]
//   csr_op      : NUM_PORTS x 2-bit op (00 none, 01 write, 10 set, 11 clear)
//   csr_wd      : NUM_PORTS x 32-bit operand
//   csr_rd      : NUM_PORTS x 32-bit pre-update read data
//   csr_illegal : NUM_PORTS illegal-access flags
// master drives the requests, slave (the CSR file) returns read data/flags.
interface csr_file_if #(
  parameter int unsigned NUM_PORTS = 3
);
  logic [NUM_PORTS*12-1:0] csr_addr;
  logic [NUM_PORTS*2-1:0]  csr_op;
  logic [NUM_PORTS*32-1:0] csr_wd;
  logic [NUM_PORTS*32-1:0] csr_rd;
  logic [NUM_PORTS-1:0]    csr_illegal;

  modport master (
    output csr_addr, csr_op, csr_wd,
    input  csr_rd, csr_illegal
  );

  modport slave (
    input  csr_addr, csr_op, csr_wd,
    output csr_rd, csr_illegal
  );
endinterface

// File: rtl/csr_file.sv
// csr_file: sparse machine-mode CSR file with NUM_PORTS read-modify-write ports.
//   clk, rst_n          : core clock, async active-low reset
//   bus (slave)         : per-port addr/op/wd in, combinational rd/illegal out
//   retire              : one instruction retired this cycle (minstret)
//   irq_ext/timer/soft  : level interrupt lines reflected in mip
// Optional feature macro: CSR_COUNTERS_EN builds mcycle/minstret and the
// user-level shadows; without it the eight counter addresses are unimplemented.
// Port 0 has the highest write priority when ports target the same CSR.
module csr_file #(
  parameter int unsigned NUM_PORTS = 3,
  parameter logic [31:0] HART_ID   = 32'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  csr_file_if.slave  bus,
  input  logic       retire,
  input  logic       irq_ext,
  input  logic       irq_timer,
  input  logic       irq_soft
);
  localparam int unsigned NP  = NUM_PORTS;
  localparam int unsigned AW  = 12;
  localparam int unsigned DW  = 32;
  localparam int unsigned OPW = 2;

  // architected storage, only the WARL-writable bits are kept
  logic          mstatus_mie_q, mstatus_mpie_q;
  logic [2:0]    mie_q;
  logic [DW-3:0] mtvec_q, mepc_q;
  logic [DW-1:0] mscratch_q, mcause_q, mtval_q;

  logic [DW-1:0] mstatus_rd, mie_rd, mip_rd;

  assign mstatus_rd = {19'd0, 2'b11, 3'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
  assign mie_rd     = {20'd0, mie_q[2], 3'd0, mie_q[1], 3'd0, mie_q[0], 3'd0};
  assign mip_rd     = {20'd0, irq_ext, 3'd0, irq_timer, 3'd0, irq_soft, 3'd0};

`ifdef CSR_COUNTERS_EN
  logic [2*DW-1:0] mcycle_q, minstret_q;
  logic            cyc_lo_we, cyc_hi_we, ins_lo_we, ins_hi_we;
  logic [DW-1:0]   cyc_lo_wd, cyc_hi_wd, ins_lo_wd, ins_hi_wd;
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

  logic [AW-1:0]  addr [NP];
  logic [OPW-1:0] op   [NP];
  logic [DW-1:0]  wd   [NP];
  logic [DW-1:0]  rdv  [NP];
  logic [DW-1:0]  nv   [NP];
  logic           impl [NP];
  logic           ill  [NP];
  logic           wen  [NP];

  // per-port read mux, illegal detection and read-modify-write value
  always_comb begin : port_decode
    for (int p = 0; p < int'(NP); p++) begin
      addr[p] = bus.csr_addr[AW*p +: AW];
      op[p]   = bus.csr_op[OPW*p +: OPW];
      wd[p]   = bus.csr_wd[DW*p +: DW];
      impl[p] = 1'b1;
      rdv[p]  = '0;
      case (addr[p])
        12'h300: rdv[p] = mstatus_rd;
        12'h301: rdv[p] = 32'h4000_0100;
        12'h304: rdv[p] = mie_rd;
        12'h305: rdv[p] = {mtvec_q, 2'b00};
        12'h340: rdv[p] = mscratch_q;
        12'h341: rdv[p] = {mepc_q, 2'b00};
        12'h342: rdv[p] = mcause_q;
        12'h343: rdv[p] = mtval_q;
        12'h344: rdv[p] = mip_rd;
        12'hF14: rdv[p] = HART_ID;
`ifdef CSR_COUNTERS_EN
        12'hB00, 12'hC00: rdv[p] = mcycle_q[DW-1:0];
        12'hB80, 12'hC80: rdv[p] = mcycle_q[2*DW-1:DW];
        12'hB02, 12'hC02: rdv[p] = minstret_q[DW-1:0];
        12'hB82, 12'hC82: rdv[p] = minstret_q[2*DW-1:DW];
`endif
        default: impl[p] = 1'b0;
      endcase
      case (op[p])
        2'b01:   nv[p] = wd[p];
        2'b10:   nv[p] = rdv[p] | wd[p];
        2'b11:   nv[p] = rdv[p] & ~wd[p];
        default: nv[p] = rdv[p];
      endcase
      // read-only space rejects writes and set/clear that would change bits
      ill[p] = (op[p] != 2'b00) &&
               (!impl[p] || ((addr[p][11:10] == 2'b11) &&
                             ((op[p] == 2'b01) || (wd[p] != '0))));
      // set/clear with a zero operand is a pure read
      wen[p] = (op[p] != 2'b00) && !ill[p] && !(op[p][1] && (wd[p] == '0));
    end
  end

  for (genvar g = 0; g < int'(NP); g++) begin : g_out
    assign bus.csr_rd[DW*g +: DW] = rdv[g];
    assign bus.csr_illegal[g]     = ill[g];
  end

  logic          mstatus_we, mie_we, mtvec_we, mscratch_we, mepc_we, mcause_we, mtval_we;
  logic [1:0]    mstatus_wd;
  logic [2:0]    mie_wd;
  logic [DW-3:0] mtvec_wd, mepc_wd;
  logic [DW-1:0] mscratch_wd, mcause_wd, mtval_wd;

  // write arbitration: iterate high to low so the lowest-index port lands last
  always_comb begin : write_arb
    mstatus_we = 1'b0; mstatus_wd = '0;
    mie_we = 1'b0; mie_wd = '0;
    mtvec_we = 1'b0; mtvec_wd = '0;
    mscratch_we = 1'b0; mscratch_wd = '0;
    mepc_we = 1'b0; mepc_wd = '0;
    mcause_we = 1'b0; mcause_wd = '0;
    mtval_we = 1'b0; mtval_wd = '0;
`ifdef CSR_COUNTERS_EN
    cyc_lo_we = 1'b0; cyc_lo_wd = '0;
    cyc_hi_we = 1'b0; cyc_hi_wd = '0;
    ins_lo_we = 1'b0; ins_lo_wd = '0;
    ins_hi_we = 1'b0; ins_hi_wd = '0;
`endif
    for (int p = int'(NP) - 1; p >= 0; p--) begin
      if (wen[p]) begin
        case (addr[p])
          12'h300: begin mstatus_we = 1'b1; mstatus_wd = {nv[p][7], nv[p][3]}; end
          12'h304: begin mie_we = 1'b1; mie_wd = {nv[p][11], nv[p][7], nv[p][3]}; end
          12'h305: begin mtvec_we = 1'b1; mtvec_wd = nv[p][DW-1:2]; end
          12'h340: begin mscratch_we = 1'b1; mscratch_wd = nv[p]; end
          12'h341: begin mepc_we = 1'b1; mepc_wd = nv[p][DW-1:2]; end
          12'h342: begin mcause_we = 1'b1; mcause_wd = nv[p]; end
          12'h343: begin mtval_we = 1'b1; mtval_wd = nv[p]; end
`ifdef CSR_COUNTERS_EN
          12'hB00: begin cyc_lo_we = 1'b1; cyc_lo_wd = nv[p]; end
          12'hB80: begin cyc_hi_we = 1'b1; cyc_hi_wd = nv[p]; end
          12'hB02: begin ins_lo_we = 1'b1; ins_lo_wd = nv[p]; end
          12'hB82: begin ins_hi_we = 1'b1; ins_hi_wd = nv[p]; end
`endif
          default: ;
        endcase
      end
    end
  end

  // architected register update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= '0;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
    end else begin
      if (mstatus_we) begin
        mstatus_mpie_q <= mstatus_wd[1];
        mstatus_mie_q  <= mstatus_wd[0];
      end
      if (mie_we)      mie_q      <= mie_wd;
      if (mtvec_we)    mtvec_q    <= mtvec_wd;
      if (mscratch_we) mscratch_q <= mscratch_wd;
      if (mepc_we)     mepc_q     <= mepc_wd;
      if (mcause_we)   mcause_q   <= mcause_wd;
      if (mtval_we)    mtval_q    <= mtval_wd;
    end
  end

`ifdef CSR_COUNTERS_EN
  // 64-bit counters; a software write to either half suppresses the increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (cyc_lo_we || cyc_hi_we) begin
        if (cyc_lo_we) mcycle_q[DW-1:0]      <= cyc_lo_wd;
        if (cyc_hi_we) mcycle_q[2*DW-1:DW]   <= cyc_hi_wd;
      end else begin
        mcycle_q <= mcycle_q + 64'd1;
      end
      if (ins_lo_we || ins_hi_we) begin
        if (ins_lo_we) minstret_q[DW-1:0]    <= ins_lo_wd;
        if (ins_hi_we) minstret_q[2*DW-1:DW] <= ins_hi_wd;
      end else if (retire) begin
        minstret_q <= minstret_q + 64'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed stimulus for csr_file with a table-driven reference
// model (address -> stored value, WARL mask, access rules) checked on every
// falling clock edge, plus hand-computed literal expectations.
module tb_csr_file;
  localparam int unsigned NP  = 3;
  localparam logic [31:0] HID = 32'h0000_0007;

  logic clk = 1'b0;
  logic rst_n;
  logic retire, irq_ext, irq_timer, irq_soft;

  always #5 clk = ~clk;

  csr_file_if #(.NUM_PORTS(NP)) bus ();

  csr_file #(.NUM_PORTS(NP), .HART_ID(HID)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .retire    (retire),
    .irq_ext   (irq_ext),
    .irq_timer (irq_timer),
    .irq_soft  (irq_soft)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  bit [31:0] store [4096];
  bit [63:0] m_cyc, m_ins;

  function automatic bit m_impl(input logic [11:0] a);
    case (a)
      12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
      12'h342, 12'h343, 12'h344, 12'hF14: return 1'b1;
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hB80, 12'hB02, 12'hB82,
      12'hC00, 12'hC80, 12'hC02, 12'hC82: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_mask(input logic [11:0] a);
    case (a)
      12'h300: return 32'h0000_0088;
      12'h304: return 32'h0000_0888;
      12'h305, 12'h341: return 32'hFFFF_FFFC;
      12'h340, 12'h342, 12'h343: return 32'hFFFF_FFFF;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    if (!m_impl(a)) return 32'h0;
    case (a)
      12'h300: return 32'h0000_1800 | store[a];
      12'h301: return 32'h4000_0100;
      12'h344: return (irq_ext ? 32'h800 : 32'h0) | (irq_timer ? 32'h80 : 32'h0) |
                      (irq_soft ? 32'h8 : 32'h0);
      12'hF14: return HID;
      12'hB00, 12'hC00: return m_cyc[31:0];
      12'hB80, 12'hC80: return m_cyc[63:32];
      12'hB02, 12'hC02: return m_ins[31:0];
      12'hB82, 12'hC82: return m_ins[63:32];
      default: return store[a];
    endcase
  endfunction

  function automatic bit m_ill(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd);
    if (op == 2'b00) return 1'b0;
    if (!m_impl(a)) return 1'b1;
    return (a[11:10] == 2'b11) && (op == 2'b01 || wd != 32'h0);
  endfunction

  function automatic bit m_wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd);
    return (op != 2'b00) && !m_ill(a, op, wd) && !(op[1] && wd == 32'h0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  // model reset: all storage clears on the asynchronous assertion
  initial begin : model_reset
    forever begin
      @(negedge rst_n);
      foreach (store[i]) store[i] = 32'h0;
      m_cyc = 64'h0;
      m_ins = 64'h0;
    end
  end

  // compare outputs at the falling edge, then commit model state at the rising edge
  initial begin : scoreboard
    logic [11:0] a;
    logic [1:0]  op;
    logic [31:0] wd, old, nv;
    logic [11:0] pa [$];
    logic [31:0] pv [$];
    bit          taken [logic [11:0]];
    bit [63:0]   nc, ni;
    bit          cw, iw;
    forever begin
      @(negedge clk);
      pa.delete();
      pv.delete();
      taken.delete();
      for (int p = 0; p < int'(NP); p++) begin
        a   = bus.csr_addr[12*p +: 12];
        op  = bus.csr_op[2*p +: 2];
        wd  = bus.csr_wd[32*p +: 32];
        old = m_read(a);
        chk($sformatf("rd%0d@%03h", p, a), bus.csr_rd[32*p +: 32], old);
        chk($sformatf("ill%0d@%03h", p, a), {31'd0, bus.csr_illegal[p]},
            {31'd0, m_ill(a, op, wd)});
        if (m_wr(a, op, wd) && !taken.exists(a)) begin
          taken[a] = 1'b1;
          case (op)
            2'b01:   nv = wd;
            2'b10:   nv = old | wd;
            default: nv = old & ~wd;
          endcase
          pa.push_back(a);
          pv.push_back(nv);
        end
      end
      nc = m_cyc; ni = m_ins; cw = 1'b0; iw = 1'b0;
      foreach (pa[i]) begin
        case (pa[i])
          12'hB00: begin nc[31:0]  = pv[i]; cw = 1'b1; end
          12'hB80: begin nc[63:32] = pv[i]; cw = 1'b1; end
          12'hB02: begin ni[31:0]  = pv[i]; iw = 1'b1; end
          12'hB82: begin ni[63:32] = pv[i]; iw = 1'b1; end
          default: ;
        endcase
      end
      if (!cw) nc = m_cyc + 64'd1;
      if (!iw && retire) ni = m_ins + 64'd1;
      @(posedge clk);
      if (rst_n) begin
        m_cyc = nc;
        m_ins = ni;
        foreach (pa[i]) store[pa[i]] = pv[i] & m_mask(pa[i]);
      end
    end
  end

  task automatic idle();
    bus.csr_addr = '0;
    bus.csr_op   = '0;
    bus.csr_wd   = '0;
  endtask

  task automatic set_port(input int p, input logic [11:0] a, input logic [1:0] op,
                          input logic [31:0] wd);
    bus.csr_addr[12*p +: 12] = a;
    bus.csr_op[2*p +: 2]     = op;
    bus.csr_wd[32*p +: 32]   = wd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rd(input int p);
    return bus.csr_rd[32*p +: 32];
  endfunction

  function automatic logic [31:0] ill(input int p);
    return {31'd0, bus.csr_illegal[p]};
  endfunction

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst_n = 1'b0;
    retire = 1'b0; irq_ext = 1'b0; irq_timer = 1'b0; irq_soft = 1'b0;
    idle();
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;

    step(); idle();
    set_port(0, 12'h301, 2'b10, 32'h0);
    set_port(1, 12'hF14, 2'b00, 32'h0);
    set_port(2, 12'h340, 2'b00, 32'h0);
    #1;
    chk("misa_rd", rd(0), 32'h4000_0100);
    chk("misa_ill", ill(0), 32'h0);
    chk("hartid", rd(1), 32'h0000_0007);
    chk("mscratch_rst", rd(2), 32'h0);

    step(); idle(); set_port(0, 12'h305, 2'b01, 32'h8000_0103);
    #1 chk("mtvec_pre", rd(0), 32'h0);
    step(); idle(); set_port(1, 12'h305, 2'b10, 32'h0000_0010);
    #1 chk("mtvec_warl", rd(1), 32'h8000_0100);
    step(); idle(); set_port(1, 12'h305, 2'b11, 32'h8000_0000);
    #1 chk("mtvec_set", rd(1), 32'h8000_0110);
    step(); idle(); set_port(2, 12'h305, 2'b00, 32'h0);
    #1 chk("mtvec_clr", rd(2), 32'h0000_0110);

    step(); idle();
    set_port(0, 12'h340, 2'b01, 32'hAAAA_AAAA);
    set_port(2, 12'h340, 2'b01, 32'h5555_5555);
    step(); idle(); set_port(1, 12'h340, 2'b00, 32'h0);
    #1 chk("prio", rd(1), 32'hAAAA_AAAA);

    step(); idle();
    set_port(0, 12'hC00, 2'b01, 32'h5);
    set_port(1, 12'h7C0, 2'b10, 32'h0);
    set_port(2, 12'h7C0, 2'b00, 32'h0);
    #1;
    chk("ro_wr_ill", ill(0), 32'h1);
    chk("unimpl_ill", ill(1), 32'h1);
    chk("unimpl_rd", rd(1), 32'h0);
    chk("noop_ill", ill(2), 32'h0);
    step(); idle(); set_port(0, 12'hC00, 2'b10, 32'h0);
`ifdef CSR_COUNTERS_EN
    #1 chk("ro_read_ill", ill(0), 32'h0);
`else
    #1 chk("ro_read_ill", ill(0), 32'h1);
`endif

    step(); idle();
    set_port(0, 12'h300, 2'b01, 32'hFFFF_FFFF);
    set_port(1, 12'h304, 2'b01, 32'hFFFF_FFFF);
    set_port(2, 12'h341, 2'b01, 32'h1234_5677);
    irq_ext = 1'b1; irq_soft = 1'b1;
    step(); idle();
    set_port(0, 12'h300, 2'b00, 32'h0);
    set_port(1, 12'h304, 2'b00, 32'h0);
    set_port(2, 12'h341, 2'b00, 32'h0);
    #1;
    chk("mstatus_warl", rd(0), 32'h0000_1888);
    chk("mie_warl", rd(1), 32'h0000_0888);
    chk("mepc_warl", rd(2), 32'h1234_5674);
    step(); idle(); set_port(0, 12'h344, 2'b01, 32'hFFFF_FFFF);
    #1;
    chk("mip_rd", rd(0), 32'h0000_0808);
    chk("mip_wr_ill", ill(0), 32'h0);
    step(); idle(); set_port(0, 12'h344, 2'b00, 32'h0);
    #1 chk("mip_ignored", rd(0), 32'h0000_0808);
    irq_ext = 1'b0; irq_soft = 1'b0; irq_timer = 1'b1;

`ifdef CSR_COUNTERS_EN
    step(); idle();
    set_port(0, 12'hB00, 2'b01, 32'hFFFF_FFFE);
    set_port(1, 12'hB80, 2'b01, 32'h0);
    set_port(2, 12'hB02, 2'b01, 32'h0);
    step(); idle(); set_port(0, 12'hB00, 2'b00, 32'h0);
    #1 chk("mcycle_wr", rd(0), 32'hFFFF_FFFE);
    step(); step(); step();
    idle();
    set_port(0, 12'hB00, 2'b00, 32'h0);
    set_port(1, 12'hB80, 2'b00, 32'h0);
    set_port(2, 12'hC80, 2'b10, 32'h0);
    #1;
    chk("mcycle_lo", rd(0), 32'h0000_0001);
    chk("mcycle_hi", rd(1), 32'h0000_0001);
    chk("cycleh_shadow", rd(2), 32'h0000_0001);
    idle();
    retire = 1'b1;
    repeat (5) step();
    retire = 1'b0;
    set_port(0, 12'hB02, 2'b00, 32'h0);
    set_port(1, 12'hC02, 2'b00, 32'h0);
    set_port(2, 12'hC82, 2'b00, 32'h0);
    #1;
    chk("minstret", rd(0), 32'h0000_0005);
    chk("instret_shadow", rd(1), 32'h0000_0005);
    chk("instreth", rd(2), 32'h0);
`else
    step(); idle();
    retire = 1'b1;
    set_port(0, 12'hB00, 2'b00, 32'h0);
    set_port(1, 12'hB00, 2'b01, 32'h0000_0123);
    #1;
    chk("nocnt_rd", rd(0), 32'h0);
    chk("nocnt_ill_rd", ill(0), 32'h0);
    chk("nocnt_ill_wr", ill(1), 32'h1);
    step();
    retire = 1'b0;
`endif

    step(); idle(); set_port(0, 12'h340, 2'b01, 32'h0000_1234);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mscratch", rd(0), 32'h0);
    chk("rst_ill", ill(0), 32'h0);
    idle();
    @(negedge clk);
    #2 rst_n = 1'b1;
    step(); idle();
    set_port(0, 12'h340, 2'b00, 32'h0);
    set_port(1, 12'h305, 2'b00, 32'h0);
    #1;
    chk("post_rst_mscratch", rd(0), 32'h0);
    chk("post_rst_mtvec", rd(1), 32'h0);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
